// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response channels and data-memory bus of the load/store unit
interface load_store_unit_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
);
    localparam int MWIDTH = DWIDTH / 8;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_wen;
    logic [MWIDTH-1:0] mem_wdata_mask;
    logic [DWIDTH-1:0] mem_rdata;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wen, mem_wdata_mask
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wen, mem_wdata_mask
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store initiator; LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors
module load_store_unit #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
) (
    input logic               clk,
    input logic               rst_n,
    load_store_unit_if.slave  bus
);
    localparam int MWIDTH = DWIDTH / 8;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            state, state_nx;
    logic              accept;
    logic [3:0]        nbytes;
    logic [MWIDTH-1:0] req_mask;
    logic [DWIDTH-1:0] req_bits;
    logic              illegal, oob, misaligned, req_err;
    logic              we_q, sext_q, err_q;
    logic [MWIDTH-1:0] mask_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q, rdata_q;
    logic [DWIDTH-1:0] ld_bits, ld_ext;
    logic              ld_sign;
    assign bus.req_ready = rst_n && state == IDLE;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.mem_addr  = addr_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    // Decode size, byte-lane mask and the error conditions of the offered request
    always_comb begin
        nbytes   = 4'd1 << bus.req_funct3[1:0];
        req_mask = MWIDTH'(bus.req_funct3[1:0] == 2'd0 ? 8'h01 :
                           bus.req_funct3[1:0] == 2'd1 ? 8'h03 :
                           bus.req_funct3[1:0] == 2'd2 ? 8'h0F : 8'hFF);
        req_bits = '0;
        for (int i = 0; i < MWIDTH; i++) req_bits[i*8 +: 8] = {8{req_mask[i]}};
        illegal  = bus.req_funct3 == 3'b111
                || (DWIDTH == 32 && (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110))
                || (bus.req_we && bus.req_funct3[2]);
        oob      = ({1'b0, bus.req_addr} + (AWIDTH+1)'(nbytes)) > ((AWIDTH+1)'(1) << AWIDTH);
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = |(bus.req_addr & AWIDTH'(nbytes - 4'd1));
`else
        misaligned = 1'b0;
`endif
        req_err  = illegal || oob || misaligned;
    end
    // Truncate the memory word to the access size and sign- or zero-extend it
    always_comb begin
        ld_bits = '0;
        for (int i = 0; i < MWIDTH; i++) ld_bits[i*8 +: 8] = {8{mask_q[i]}};
        ld_sign = sext_q && |(bus.mem_rdata & (ld_bits ^ (ld_bits >> 1)));
        ld_ext  = (bus.mem_rdata & ld_bits) | (ld_sign ? ~ld_bits : '0);
    end
    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // Next state and the memory/response strobes, which are only live in ACCESS/RESP
    always_comb begin
        state_nx           = state;
        bus.rsp_valid      = 1'b0;
        bus.mem_wen        = 1'b0;
        bus.mem_wdata_mask = '0;
        bus.mem_wdata      = '0;
        unique case (state)
            IDLE:    state_nx = accept ? (req_err ? RESP : ACCESS) : IDLE;
            ACCESS: begin
                state_nx           = RESP;
                bus.mem_wen        = we_q;
                bus.mem_wdata_mask = we_q ? mask_q : '0;
                bus.mem_wdata      = we_q ? wdata_q : '0;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_nx      = bus.rsp_ready ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Register the accepted request; capture load data at the end of ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            sext_q  <= ~bus.req_funct3[2];
            err_q   <= req_err;
            mask_q  <= req_mask;
            wdata_q <= bus.req_wdata & req_bits;
            rdata_q <= '0;
            if (!req_err) addr_q <= bus.req_addr;
        end else if (state == ACCESS && !we_q) begin
            rdata_q <= ld_ext;
        end
    end
endmodule
